// File: rtl/srom_rd.sv
// -----------------------------------------------------------------------------
// srom_rd : memory-side read engine for the sound-ROM path.
//
// Takes single-cycle word read requests from the bus chip-select stage and runs
// a timed read cycle on an external 16-bit asynchronous ROM/SRAM. mem_oe_n is
// held low for WAIT cycles with a stable address. The word is then returned with
// a one-cycle msack pulse. A one-entry pending slot absorbs a request that
// arrives while the engine is busy.
//
// Parameters:
//   AW   word address width
//   WAIT cycles mem_oe_n is held low before data is sampled (1..15)
//   HOLD recovery cycles with mem_oe_n high between accesses (0..7)
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   msreq, msaddr     read request pulse and word address
//   msack, msdata     read-complete pulse and read word (held until next msack)
//   mem_addr,mem_oe_n external ROM address and active-low output enable
//   mem_data          external ROM data
//   busy              engine not idle, or pending slot occupied
//   ovf               sticky: a request was dropped (cleared only by rst)
//
// Optional feature (macro SROM_RD_LASTWORD_EN): remembers the last completed
// address. A repeat request from IDLE is answered next cycle without an
// external access.
// -----------------------------------------------------------------------------
module srom_rd #(
    parameter int unsigned AW   = 17,
    parameter int unsigned WAIT = 4,
    parameter int unsigned HOLD = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          msreq,
    input  logic [AW-1:0] msaddr,
    output logic          msack,
    output logic [15:0]   msdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_oe_n,
    input  logic [15:0]   mem_data,
    output logic          busy,
    output logic          ovf
);

    localparam int unsigned CW = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic          mem_oe_n_q,  mem_oe_n_d;
    logic          msack_q,     msack_d;
    logic [15:0]   msdata_q,    msdata_d;
    logic          pend_v_q,    pend_v_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic          ovf_q,       ovf_d;
    logic          busy_q,      busy_d;
`ifdef SROM_RD_LASTWORD_EN
    logic          last_v_q,    last_v_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
`endif

    logic          start_req;
    logic          req_taken;

    // Next-state, datapath and pending-slot logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_oe_n_d  = mem_oe_n_q;
        msack_d     = 1'b0;
        msdata_d    = msdata_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        ovf_d       = ovf_q;
`ifdef SROM_RD_LASTWORD_EN
        last_v_d    = last_v_q;
        last_addr_d = last_addr_q;
`endif
        start_req   = 1'b0;
        req_taken   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pend_v_q || msreq) begin
`ifdef SROM_RD_LASTWORD_EN
                    // Repeat of the last completed word: answer from msdata
                    if (!pend_v_q && last_v_q && (msaddr == last_addr_q)) begin
                        msack_d   = 1'b1;
                        req_taken = 1'b1;
                    end else begin
                        start_req = 1'b1;
                    end
`else
                    start_req = 1'b1;
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    msdata_d   = mem_data;
                    msack_d    = 1'b1;
                    mem_oe_n_d = 1'b1;
                    state_d    = ST_RECOVER;
                    // The msack cycle counts as the first oe-high cycle;
                    // HOLD further cycles follow before the next access.
                    cnt_d      = CW'(HOLD);
`ifdef SROM_RD_LASTWORD_EN
                    last_v_d    = 1'b1;
                    last_addr_d = mem_addr_q;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            ST_RECOVER: begin
                if (cnt_q == '0) begin
                    if (pend_v_q || msreq) begin
                        start_req = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                mem_oe_n_d = 1'b1;
            end
        endcase

        // Start an access; the pending entry always wins over a new request
        if (start_req) begin
            state_d    = ST_ACCESS;
            cnt_d      = CW'(WAIT - 1);
            mem_oe_n_d = 1'b0;
            if (pend_v_q) begin
                mem_addr_d = pend_addr_q;
                pend_v_d   = 1'b0;
            end else begin
                mem_addr_d = msaddr;
                req_taken  = 1'b1;
            end
        end

        // A request not consumed above goes to the slot, using its
        // post-start occupancy so a just-freed slot accepts it.
        if (msreq && !req_taken) begin
            if (pend_v_d) begin
                ovf_d = 1'b1;
            end else begin
                pend_v_d    = 1'b1;
                pend_addr_d = msaddr;
            end
        end

        busy_d = (state_d != ST_IDLE) || pend_v_d;
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_oe_n_q  <= 1'b1;
            msack_q     <= 1'b0;
            msdata_q    <= '0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SROM_RD_LASTWORD_EN
            last_v_q    <= 1'b0;
            last_addr_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_oe_n_q  <= mem_oe_n_d;
            msack_q     <= msack_d;
            msdata_q    <= msdata_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
`ifdef SROM_RD_LASTWORD_EN
            last_v_q    <= last_v_d;
            last_addr_q <= last_addr_d;
`endif
        end
    end

    assign msack    = msack_q;
    assign msdata   = msdata_q;
    assign mem_addr = mem_addr_q;
    assign mem_oe_n = mem_oe_n_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_srom_rd.sv
// -----------------------------------------------------------------------------
// tb_srom_rd : directed self-checking bench for srom_rd.
// dut0 runs WAIT=4/HOLD=1, dut1 runs WAIT=1/HOLD=0. Cycle c of a scenario is
// the clock period in which msreq for that cycle is presented; outputs are
// sampled 1 time unit after the rising edge that opens the cycle.
// -----------------------------------------------------------------------------
module tb_srom_rd;

    logic        clk;
    logic        rst;

    logic        msreq;
    logic [16:0] msaddr;
    logic        msack;
    logic [15:0] msdata;
    logic [16:0] mem_addr;
    logic        mem_oe_n;
    logic [15:0] mem_data;
    logic        busy;
    logic        ovf;

    logic        msreq1;
    logic [16:0] msaddr1;
    logic        msack1;
    logic [15:0] msdata1;
    logic [16:0] mem_addr1;
    logic        mem_oe_n1;
    logic [15:0] mem_data1;
    logic        busy1;
    logic        ovf1;

    logic        use_rom;
    logic [15:0] fixed_data;

    int errors;
    int checks;

    srom_rd #(.AW(17), .WAIT(4), .HOLD(1)) dut0 (
        .clk(clk), .rst(rst), .msreq(msreq), .msaddr(msaddr),
        .msack(msack), .msdata(msdata), .mem_addr(mem_addr),
        .mem_oe_n(mem_oe_n), .mem_data(mem_data), .busy(busy), .ovf(ovf)
    );

    srom_rd #(.AW(17), .WAIT(1), .HOLD(0)) dut1 (
        .clk(clk), .rst(rst), .msreq(msreq1), .msaddr(msaddr1),
        .msack(msack1), .msdata(msdata1), .mem_addr(mem_addr1),
        .mem_oe_n(mem_oe_n1), .mem_data(mem_data1), .busy(busy1), .ovf(ovf1)
    );

    // ROM model: word at address a is {a[15:0]} ^ 16'h5A00
    always_comb begin
        mem_data  = use_rom ? (mem_addr[15:0] ^ 16'h5A00) : fixed_data;
        mem_data1 = mem_addr1[15:0] ^ 16'h5A00;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if (msack !== 1'b0)       begin errors++; $display("FAIL rst_msack got %b exp 0", msack); end
        checks++; if (msdata !== 16'h0)     begin errors++; $display("FAIL rst_msdata got %h exp 0000", msdata); end
        checks++; if (mem_addr !== 17'h0)   begin errors++; $display("FAIL rst_mem_addr got %h exp 00000", mem_addr); end
        checks++; if (mem_oe_n !== 1'b1)    begin errors++; $display("FAIL rst_oe got %b exp 1", mem_oe_n); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0)         begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
        checks++; if (mem_oe_n1 !== 1'b1)   begin errors++; $display("FAIL rst_oe1 got %b exp 1", mem_oe_n1); end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic exp_oe;
        logic exp_ack;
        use_rom = 1'b0;
        fixed_data = 16'hBEEF;
        for (int c = 0; c < 8; c++) begin
            msreq  = (c == 0);
            msaddr = (c == 0) ? 17'h00123 : 17'h1FFFF;
            exp_oe  = !(c >= 1 && c <= 4);
            exp_ack = (c == 5);
            checks++; if (mem_oe_n !== exp_oe) begin errors++; $display("FAIL single_oe c=%0d got %b exp %b", c, mem_oe_n, exp_oe); end
            checks++; if (msack !== exp_ack)   begin errors++; $display("FAIL single_ack c=%0d got %b exp %b", c, msack, exp_ack); end
            if (c >= 1 && c <= 4) begin
                checks++; if (mem_addr !== 17'h00123) begin errors++; $display("FAIL single_addr c=%0d got %h exp 00123", c, mem_addr); end
            end
            if (c == 5) begin
                checks++; if (msdata !== 16'hBEEF) begin errors++; $display("FAIL single_data got %h exp BEEF", msdata); end
            end
            if (c == 3) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b exp 1", busy); end
            end
            if (c == 7) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b exp 0", busy); end
            end
            tick();
        end
        msreq = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_oe;
        logic exp_ack;
        use_rom = 1'b1;
        for (int c = 0; c < 14; c++) begin
            msreq  = (c == 0) || (c == 2);
            msaddr = (c == 0) ? 17'h00010 : 17'h00011;
            exp_oe  = !((c >= 1 && c <= 4) || (c >= 7 && c <= 10));
            exp_ack = (c == 5) || (c == 11);
            checks++; if (mem_oe_n !== exp_oe) begin errors++; $display("FAIL b2b_oe c=%0d got %b exp %b", c, mem_oe_n, exp_oe); end
            checks++; if (msack !== exp_ack)   begin errors++; $display("FAIL b2b_ack c=%0d got %b exp %b", c, msack, exp_ack); end
            if (c == 5 || c == 8) begin
                checks++; if (msdata !== 16'h5A10) begin errors++; $display("FAIL b2b_data0 c=%0d got %h exp 5A10", c, msdata); end
            end
            if (c == 8) begin
                checks++; if (mem_addr !== 17'h00011) begin errors++; $display("FAIL b2b_addr1 got %h exp 00011", mem_addr); end
            end
            if (c == 11) begin
                checks++; if (msdata !== 16'h5A11) begin errors++; $display("FAIL b2b_data1 got %h exp 5A11", msdata); end
            end
            tick();
        end
        msreq = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_overflow();
        int acks;
        logic exp_ovf;
        acks = 0;
        use_rom = 1'b1;
        for (int c = 0; c < 16; c++) begin
            msreq  = (c <= 2);
            msaddr = 17'h00020 + 17'(c);
            exp_ovf = (c >= 3);
            if (msack === 1'b1) acks++;
            checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL ovf_flag c=%0d got %b exp %b", c, ovf, exp_ovf); end
            if (c == 5) begin
                checks++; if (msdata !== 16'h5A20) begin errors++; $display("FAIL ovf_data0 got %h exp 5A20", msdata); end
            end
            if (c == 11) begin
                checks++; if (msdata !== 16'h5A21) begin errors++; $display("FAIL ovf_data1 got %h exp 5A21", msdata); end
            end
            tick();
        end
        msreq = 1'b0;
        checks++; if (acks != 2) begin errors++; $display("FAIL ovf_ackcount got %0d exp 2", acks); end
    endtask

    task automatic test_async_reset();
        logic exp_ack;
        use_rom = 1'b1;
        for (int c = 0; c < 3; c++) begin
            msreq  = (c == 0);
            msaddr = 17'h00030;
            tick();
        end
        msreq = 1'b0;
        checks++; if (mem_oe_n !== 1'b0) begin errors++; $display("FAIL arst_pre_oe got %b exp 0", mem_oe_n); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_oe_n !== 1'b1) begin errors++; $display("FAIL arst_oe got %b exp 1", mem_oe_n); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL arst_busy got %b exp 0", busy); end
        checks++; if (ovf !== 1'b0)      begin errors++; $display("FAIL arst_ovf got %b exp 0", ovf); end
        checks++; if (msdata !== 16'h0)  begin errors++; $display("FAIL arst_msdata got %h exp 0000", msdata); end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++; if (msack !== 1'b0) begin errors++; $display("FAIL arst_noack c=%0d got %b exp 0", c, msack); end
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            msreq  = (c == 0);
            msaddr = 17'h00031;
            exp_ack = (c == 5);
            checks++; if (msack !== exp_ack) begin errors++; $display("FAIL arst_relat c=%0d got %b exp %b", c, msack, exp_ack); end
            if (c == 5) begin
                checks++; if (msdata !== 16'h5A31) begin errors++; $display("FAIL arst_data got %h exp 5A31", msdata); end
            end
            tick();
        end
        msreq = 1'b0;
    endtask

    task automatic test_wait1();
        logic exp_oe;
        logic exp_ack;
        logic [15:0] exp_data;
        for (int c = 0; c < 11; c++) begin
            msreq1  = (c < 8) && (c % 2 == 0);
            msaddr1 = 17'h00040 + 17'(c / 2);
            exp_oe  = !((c % 2 == 1) && (c <= 7));
            exp_ack = (c % 2 == 0) && (c >= 2) && (c <= 8);
            checks++; if (mem_oe_n1 !== exp_oe) begin errors++; $display("FAIL w1_oe c=%0d got %b exp %b", c, mem_oe_n1, exp_oe); end
            checks++; if (msack1 !== exp_ack)   begin errors++; $display("FAIL w1_ack c=%0d got %b exp %b", c, msack1, exp_ack); end
            if (exp_ack) begin
                exp_data = 16'h5A40 + 16'(c / 2 - 1);
                checks++; if (msdata1 !== exp_data) begin errors++; $display("FAIL w1_data c=%0d got %h exp %h", c, msdata1, exp_data); end
            end
            tick();
        end
        msreq1 = 1'b0;
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL w1_ovf got %b exp 0", ovf1); end
    endtask

    task automatic test_lastword();
        logic exp_oe;
        logic exp_ack;
        use_rom = 1'b0;
        fixed_data = 16'h1234;
        for (int c = 0; c < 8; c++) begin
            msreq  = (c == 0);
            msaddr = 17'h00042;
            exp_ack = (c == 5);
            checks++; if (msack !== exp_ack) begin errors++; $display("FAIL lw_first_ack c=%0d got %b exp %b", c, msack, exp_ack); end
            if (c == 5) begin
                checks++; if (msdata !== 16'h1234) begin errors++; $display("FAIL lw_first_data got %h exp 1234", msdata); end
            end
            tick();
        end
        // Repeat the same address while the ROM now returns a different word
        fixed_data = 16'h9999;
        for (int c = 0; c < 8; c++) begin
            msreq  = (c == 0);
            msaddr = 17'h00042;
`ifdef SROM_RD_LASTWORD_EN
            exp_oe  = 1'b1;
            exp_ack = (c == 1);
`else
            exp_oe  = !(c >= 1 && c <= 4);
            exp_ack = (c == 5);
`endif
            checks++; if (mem_oe_n !== exp_oe) begin errors++; $display("FAIL lw_rep_oe c=%0d got %b exp %b", c, mem_oe_n, exp_oe); end
            checks++; if (msack !== exp_ack)   begin errors++; $display("FAIL lw_rep_ack c=%0d got %b exp %b", c, msack, exp_ack); end
`ifdef SROM_RD_LASTWORD_EN
            if (c == 1) begin
                checks++; if (msdata !== 16'h1234) begin errors++; $display("FAIL lw_hit_data got %h exp 1234", msdata); end
            end
`else
            if (c == 5) begin
                checks++; if (msdata !== 16'h9999) begin errors++; $display("FAIL lw_rep_data got %h exp 9999", msdata); end
            end
`endif
            tick();
        end
        msreq = 1'b0;
        // After reset the remembered word is gone: full access again
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        for (int c = 0; c < 8; c++) begin
            msreq  = (c == 0);
            msaddr = 17'h00042;
            exp_oe  = !(c >= 1 && c <= 4);
            exp_ack = (c == 5);
            checks++; if (mem_oe_n !== exp_oe) begin errors++; $display("FAIL lw_post_oe c=%0d got %b exp %b", c, mem_oe_n, exp_oe); end
            checks++; if (msack !== exp_ack)   begin errors++; $display("FAIL lw_post_ack c=%0d got %b exp %b", c, msack, exp_ack); end
            if (c == 5) begin
                checks++; if (msdata !== 16'h9999) begin errors++; $display("FAIL lw_post_data got %h exp 9999", msdata); end
            end
            tick();
        end
        msreq = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        rst        = 1'b1;
        msreq      = 1'b0;
        msaddr     = '0;
        msreq1     = 1'b0;
        msaddr1    = '0;
        use_rom    = 1'b0;
        fixed_data = 16'h0000;

        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        test_wait1();
        test_lastword();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
